// File: rtl/axil_rr_arbiter.sv
// Shares one AXI4-lite slave between S_COUNT masters; independent write/read arbiters, one outstanding transfer each.
// Define AXIL_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module axil_rr_arbiter #(
    parameter int S_COUNT    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [S_COUNT*ADDR_WIDTH-1:0]    s_axil_awaddr,
    input  logic [S_COUNT*3-1:0]             s_axil_awprot,
    input  logic [S_COUNT-1:0]               s_axil_awvalid,
    output logic [S_COUNT-1:0]               s_axil_awready,
    input  logic [S_COUNT*DATA_WIDTH-1:0]    s_axil_wdata,
    input  logic [S_COUNT*STRB_WIDTH-1:0]    s_axil_wstrb,
    input  logic [S_COUNT-1:0]               s_axil_wvalid,
    output logic [S_COUNT-1:0]               s_axil_wready,
    output logic [S_COUNT*2-1:0]             s_axil_bresp,
    output logic [S_COUNT-1:0]               s_axil_bvalid,
    input  logic [S_COUNT-1:0]               s_axil_bready,
    input  logic [S_COUNT*ADDR_WIDTH-1:0]    s_axil_araddr,
    input  logic [S_COUNT*3-1:0]             s_axil_arprot,
    input  logic [S_COUNT-1:0]               s_axil_arvalid,
    output logic [S_COUNT-1:0]               s_axil_arready,
    output logic [S_COUNT*DATA_WIDTH-1:0]    s_axil_rdata,
    output logic [S_COUNT*2-1:0]             s_axil_rresp,
    output logic [S_COUNT-1:0]               s_axil_rvalid,
    input  logic [S_COUNT-1:0]               s_axil_rready,
    output logic [ADDR_WIDTH-1:0]            m_axil_awaddr,
    output logic [2:0]                       m_axil_awprot,
    output logic                             m_axil_awvalid,
    input  logic                             m_axil_awready,
    output logic [DATA_WIDTH-1:0]            m_axil_wdata,
    output logic [STRB_WIDTH-1:0]            m_axil_wstrb,
    output logic                             m_axil_wvalid,
    input  logic                             m_axil_wready,
    input  logic [1:0]                       m_axil_bresp,
    input  logic                             m_axil_bvalid,
    output logic                             m_axil_bready,
    output logic [ADDR_WIDTH-1:0]            m_axil_araddr,
    output logic [2:0]                       m_axil_arprot,
    output logic                             m_axil_arvalid,
    input  logic                             m_axil_arready,
    input  logic [DATA_WIDTH-1:0]            m_axil_rdata,
    input  logic [1:0]                       m_axil_rresp,
    input  logic                             m_axil_rvalid,
    output logic                             m_axil_rready
);
    localparam int IDX_W = (S_COUNT > 1) ? $clog2(S_COUNT) : 1;

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_RESP} r_state_t;

    w_state_t            w_state_q, w_state_d;
    r_state_t            r_state_q, r_state_d;
    logic [IDX_W-1:0]    w_grant_q, w_grant_d, r_grant_q, r_grant_d;
    logic                aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic [IDX_W-1:0]    w_base, r_base;
    logic [IDX_W:0]      w_pick, r_pick;
    logic                aw_hs, w_hs, b_hs, ar_hs, r_hs;

    // Returns {found, index}: first requester at or after base, wrapping modulo S_COUNT.
    function automatic logic [IDX_W:0] pick(input logic [S_COUNT-1:0] req,
                                            input logic [IDX_W-1:0]  base);
        logic             found;
        logic [IDX_W-1:0] sel;
        logic [IDX_W-1:0] cand;
        int unsigned      idx;
        found = 1'b0;
        sel   = base;
        for (int unsigned k = 0; k < S_COUNT; k++) begin
            idx  = (32'(base) + k) % 32'(S_COUNT);
            cand = IDX_W'(idx);
            if (!found && req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
        return {found, sel};
    endfunction

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] g);
        return (g == IDX_W'(S_COUNT - 1)) ? '0 : g + 1'b1;
    endfunction

`ifdef AXIL_ARB_FIXED_PRIO_EN
    assign w_base = '0;
    assign r_base = '0;
`else
    logic [IDX_W-1:0] w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
        end
    end

    always_comb begin
        w_ptr_d = w_ptr_q;
        r_ptr_d = r_ptr_q;
        if (w_state_q == W_IDLE && w_pick[IDX_W]) w_ptr_d = wrap_inc(w_pick[IDX_W-1:0]);
        if (r_state_q == R_IDLE && r_pick[IDX_W]) r_ptr_d = wrap_inc(r_pick[IDX_W-1:0]);
    end

    assign w_base = w_ptr_q;
    assign r_base = r_ptr_q;
`endif

    assign w_pick = pick(s_axil_awvalid | s_axil_wvalid, w_base);
    assign r_pick = pick(s_axil_arvalid, r_base);

    assign aw_hs = m_axil_awvalid && m_axil_awready;
    assign w_hs  = m_axil_wvalid && m_axil_wready;
    assign b_hs  = m_axil_bvalid && m_axil_bready;
    assign ar_hs = m_axil_arvalid && m_axil_arready;
    assign r_hs  = m_axil_rvalid && m_axil_rready;

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            w_grant_q <= '0;
            r_grant_q <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            w_grant_q <= w_grant_d;
            r_grant_q <= r_grant_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        w_grant_d = w_grant_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (w_state_q)
            W_IDLE: if (w_pick[IDX_W]) begin
                w_grant_d = w_pick[IDX_W-1:0];
                w_state_d = W_ADDR;
            end
            W_ADDR: begin
                aw_done_d = aw_done_q | aw_hs;
                w_done_d  = w_done_q | w_hs;
                // AW and W may finish in either order or together.
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) w_state_d = W_RESP;
            end
            W_RESP: if (b_hs) begin
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        r_grant_d = r_grant_q;
        case (r_state_q)
            R_IDLE: if (r_pick[IDX_W]) begin
                r_grant_d = r_pick[IDX_W-1:0];
                r_state_d = R_ADDR;
            end
            R_ADDR:  if (ar_hs) r_state_d = R_RESP;
            R_RESP:  if (r_hs) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        m_axil_awaddr  = s_axil_awaddr[w_grant_q*ADDR_WIDTH +: ADDR_WIDTH];
        m_axil_awprot  = s_axil_awprot[w_grant_q*3 +: 3];
        m_axil_wdata   = s_axil_wdata[w_grant_q*DATA_WIDTH +: DATA_WIDTH];
        m_axil_wstrb   = s_axil_wstrb[w_grant_q*STRB_WIDTH +: STRB_WIDTH];
        m_axil_awvalid = 1'b0;
        m_axil_wvalid  = 1'b0;
        m_axil_bready  = 1'b0;
        s_axil_awready = '0;
        s_axil_wready  = '0;
        s_axil_bvalid  = '0;
        s_axil_bresp   = '0;
        case (w_state_q)
            W_ADDR: begin
                m_axil_awvalid            = s_axil_awvalid[w_grant_q] && !aw_done_q;
                s_axil_awready[w_grant_q] = m_axil_awready && !aw_done_q;
                m_axil_wvalid             = s_axil_wvalid[w_grant_q] && !w_done_q;
                s_axil_wready[w_grant_q]  = m_axil_wready && !w_done_q;
            end
            W_RESP: begin
                s_axil_bvalid[w_grant_q]       = m_axil_bvalid;
                s_axil_bresp[w_grant_q*2 +: 2] = m_axil_bresp;
                m_axil_bready                  = s_axil_bready[w_grant_q];
            end
            default: ;
        endcase
    end

    always_comb begin
        m_axil_araddr  = s_axil_araddr[r_grant_q*ADDR_WIDTH +: ADDR_WIDTH];
        m_axil_arprot  = s_axil_arprot[r_grant_q*3 +: 3];
        m_axil_arvalid = 1'b0;
        m_axil_rready  = 1'b0;
        s_axil_arready = '0;
        s_axil_rvalid  = '0;
        s_axil_rdata   = '0;
        s_axil_rresp   = '0;
        case (r_state_q)
            R_ADDR: begin
                m_axil_arvalid            = s_axil_arvalid[r_grant_q];
                s_axil_arready[r_grant_q] = m_axil_arready;
            end
            R_RESP: begin
                s_axil_rvalid[r_grant_q]                        = m_axil_rvalid;
                s_axil_rdata[r_grant_q*DATA_WIDTH +: DATA_WIDTH] = m_axil_rdata;
                s_axil_rresp[r_grant_q*2 +: 2]                  = m_axil_rresp;
                m_axil_rready                                   = s_axil_rready[r_grant_q];
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_axil_rr_arbiter.sv
// Directed self-checking bench for axil_rr_arbiter with two masters and a hand-driven slave.
module tb_axil_rr_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] s_awaddr, s_araddr, s_wdata, s_rdata;
    logic [5:0]  s_awprot, s_arprot;
    logic [7:0]  s_wstrb;
    logic [3:0]  s_bresp, s_rresp;
    logic [1:0]  s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [1:0]  s_arvalid, s_arready, s_rvalid, s_rready;
    logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
    logic [2:0]  m_awprot, m_arprot;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp, m_rresp;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic [14:0] all_vr;
    int          checks = 0;
    int          errors = 0;
    int          exp_port;

    axil_rr_arbiter #(.S_COUNT(2), .DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .s_axil_awaddr(s_awaddr), .s_axil_awprot(s_awprot), .s_axil_awvalid(s_awvalid), .s_axil_awready(s_awready),
        .s_axil_wdata(s_wdata), .s_axil_wstrb(s_wstrb), .s_axil_wvalid(s_wvalid), .s_axil_wready(s_wready),
        .s_axil_bresp(s_bresp), .s_axil_bvalid(s_bvalid), .s_axil_bready(s_bready),
        .s_axil_araddr(s_araddr), .s_axil_arprot(s_arprot), .s_axil_arvalid(s_arvalid), .s_axil_arready(s_arready),
        .s_axil_rdata(s_rdata), .s_axil_rresp(s_rresp), .s_axil_rvalid(s_rvalid), .s_axil_rready(s_rready),
        .m_axil_awaddr(m_awaddr), .m_axil_awprot(m_awprot), .m_axil_awvalid(m_awvalid), .m_axil_awready(m_awready),
        .m_axil_wdata(m_wdata), .m_axil_wstrb(m_wstrb), .m_axil_wvalid(m_wvalid), .m_axil_wready(m_wready),
        .m_axil_bresp(m_bresp), .m_axil_bvalid(m_bvalid), .m_axil_bready(m_bready),
        .m_axil_araddr(m_araddr), .m_axil_arprot(m_arprot), .m_axil_arvalid(m_arvalid), .m_axil_arready(m_arready),
        .m_axil_rdata(m_rdata), .m_axil_rresp(m_rresp), .m_axil_rvalid(m_rvalid), .m_axil_rready(m_rready)
    );

    always #5 clk = ~clk;

    assign all_vr = {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready,
                     s_awready, s_wready, s_bvalid, s_arready, s_rvalid};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1;
        s_awaddr = '0; s_awprot = '0; s_awvalid = '0; s_wdata = '0; s_wstrb = '0; s_wvalid = '0;
        s_bready = '0; s_araddr = '0; s_arprot = '0; s_arvalid = '0; s_rready = '0;
        m_awready = 1'b1; m_wready = 1'b1; m_arready = 1'b1;
        m_bvalid = 1'b0; m_bresp = '0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0;
        tick(); tick();
        check("reset_vr", 64'(all_vr), 64'h0);
        rst = 1'b0;

        // Single write on port 1
        s_awaddr[63:32] = 32'h10; s_awprot[5:3] = 3'b010; s_awvalid = 2'b10;
        s_wdata[63:32] = 32'hDEADBEEF; s_wstrb[7:4] = 4'hF; s_wvalid = 2'b10;
        settle();
        check("wr1_idle_novalid", {62'h0, m_awvalid, m_wvalid}, 64'h0);
        tick();
        check("wr1_m_valids", {62'h0, m_awvalid, m_wvalid}, 64'h3);
        check("wr1_awaddr", 64'(m_awaddr), 64'h10);
        check("wr1_awprot", 64'(m_awprot), 64'h2);
        check("wr1_wdata", 64'(m_wdata), 64'hDEADBEEF);
        check("wr1_s_ready", {60'h0, s_awready, s_wready}, 64'hA);
        tick();
        s_awvalid = '0; s_wvalid = '0;
        m_bvalid = 1'b1; m_bresp = 2'b00; s_bready = 2'b10;
        settle();
        check("wr1_bvalid", 64'(s_bvalid), 64'h2);
        check("wr1_bresp", 64'(s_bresp), 64'h0);
        check("wr1_bready", 64'(m_bready), 64'h1);
        tick();
        m_bvalid = 1'b0; s_bready = '0;
        settle();
        check("wr1_idle_after_b", 64'(all_vr), 64'h0);

        // Split AW/W on port 0: W leads AW by 3 cycles
        s_wdata[31:0] = 32'h12345678; s_wstrb[3:0] = 4'h3; s_wvalid = 2'b01;
        tick();
        check("split_w_first", {62'h0, m_awvalid, m_wvalid}, 64'h1);
        check("split_wready", 64'(s_wready), 64'h1);
        check("split_wdata", 64'(m_wdata), 64'h12345678);
        tick();
        s_wvalid = '0;
        settle();
        check("split_w_done", {61'h0, m_awvalid, m_wvalid, m_bready}, 64'h0);
        tick();
        s_awaddr[31:0] = 32'h44; s_awvalid = 2'b01;
        settle();
        check("split_aw_late", {62'h0, m_awvalid, m_wvalid}, 64'h2);
        check("split_awaddr", 64'(m_awaddr), 64'h44);
        tick();
        s_awvalid = '0;
        m_bvalid = 1'b1; m_bresp = 2'b01; s_bready = 2'b01;
        settle();
        check("split_bvalid", 64'(s_bvalid), 64'h1);
        check("split_bresp", 64'(s_bresp), 64'h1);
        tick();
        check("split_single_b", 64'(s_bvalid), 64'h0);
        m_bvalid = 1'b0; s_bready = '0;

        // Read contention: both ports hold arvalid for eight reads
        s_araddr = {32'h200, 32'h100}; s_arvalid = 2'b11; s_rready = 2'b11;
        for (int k = 0; k < 8; k++) begin
`ifdef AXIL_ARB_FIXED_PRIO_EN
            exp_port = 0;
`else
            exp_port = k % 2;
`endif
            tick();
            check("cont_arready", 64'(s_arready), 64'(1 << exp_port));
            check("cont_araddr", 64'(m_araddr), (exp_port == 0) ? 64'h100 : 64'h200);
            tick();
            m_rvalid = 1'b1; m_rdata = 32'(k);
            settle();
            check("cont_rvalid", 64'(s_rvalid), 64'(1 << exp_port));
            check("cont_rdata", 64'(s_rdata[exp_port*32 +: 32]), 64'(k));
            tick();
            m_rvalid = 1'b0;
        end
        s_arvalid = '0;

        // Concurrent write on port 0 and read on port 1
        s_awaddr[31:0] = 32'h80; s_awvalid = 2'b01; s_wvalid = 2'b01; s_arvalid = 2'b10;
        tick();
        check("conc_addr_phase", {61'h0, m_awvalid, m_wvalid, m_arvalid}, 64'h7);
        tick();
        s_awvalid = '0; s_wvalid = '0; s_arvalid = '0;
        m_bvalid = 1'b1; m_bresp = 2'b00; s_bready = 2'b01;
        m_rvalid = 1'b1; m_rdata = 32'hCAFE0001; m_rresp = 2'b00;
        settle();
        check("conc_resp", {60'h0, s_bvalid, s_rvalid}, 64'h6);
        check("conc_rdata", 64'(s_rdata[63:32]), 64'hCAFE0001);
        tick();
        check("conc_done", {60'h0, s_bvalid, s_rvalid}, 64'h0);
        m_bvalid = 1'b0; m_rvalid = 1'b0; s_bready = '0;

        // B backpressure on port 0 with port 1 waiting
        s_awaddr[31:0] = 32'h90; s_awvalid = 2'b01; s_wvalid = 2'b01;
        tick();
        tick();
        s_awvalid = 2'b10; s_wvalid = 2'b10; s_awaddr[63:32] = 32'h20;
        m_bvalid = 1'b1; m_bresp = 2'b10; s_bready = 2'b00;
        for (int k = 0; k < 5; k++) begin
            settle();
            check("bp_bvalid_held", 64'(s_bvalid), 64'h1);
            check("bp_bresp", 64'(s_bresp), 64'h2);
            check("bp_no_grant", {61'h0, m_awvalid, s_awready}, 64'h0);
            tick();
        end
        s_bready = 2'b01;
        settle();
        check("bp_bready", 64'(m_bready), 64'h1);
        tick();
        m_bvalid = 1'b0; s_bready = '0;
        settle();
        check("bp_idle_after", 64'(m_awvalid), 64'h0);
        tick();
        check("bp_next_grant", 64'(s_awready), 64'h2);
        check("bp_next_addr", 64'(m_awaddr), 64'h20);
        tick();
        s_awvalid = '0; s_wvalid = '0; m_bvalid = 1'b1; s_bready = 2'b10;
        tick();
        m_bvalid = 1'b0; s_bready = '0;

        // Reset while in R_RESP
        s_araddr = {32'h200, 32'h100}; s_arvalid = 2'b01;
        tick();
        tick();
        s_arvalid = '0; m_rvalid = 1'b1; m_rdata = 32'h55;
        settle();
        check("rst_pre_rvalid", 64'(s_rvalid), 64'h1);
        rst = 1'b1;
        tick();
        check("rst_mid_vr", 64'(all_vr), 64'h0);
        rst = 1'b0; m_rvalid = 1'b0;
        s_arvalid = 2'b11;
        tick();
        check("rst_ptr_zero", 64'(s_arready), 64'h1);
        tick();
        s_arvalid = 2'b10; m_rvalid = 1'b1; m_rdata = 32'h66;
        tick();
        m_rvalid = 1'b0;
        tick();
        check("rst_port1_grant", 64'(s_arready), 64'h2);
        tick();
        s_arvalid = '0; m_rvalid = 1'b1; m_rdata = 32'h77;
        settle();
        check("rst_port1_rdata", 64'(s_rdata[63:32]), 64'h77);
        tick();
        m_rvalid = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
